flag_cond_unit: RTL and testbench

FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

---
 rtl/flag_cond_unit.sv | 115 +++++++++++
 tb/tb_flag_cond_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_unit.sv
// Condition evaluation and NZCV flag register with a one-entry valid/ready output stage.
// Each accepted instruction is tested against the flags held before its accept edge.
module flag_cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       aluC,
    input  logic       aluZ,
    input  logic       aluN,
    input  logic       aluV,
    input  logic       flagWrite,
    input  logic [3:0] condField,
    input  logic       inValid,
    output logic       inReady,
    output logic       outValid,
    input  logic       outReady,
    output logic       condPass,
    output logic       carryOut,
    output logic [3:0] nzcv,
    input  logic       debug
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_p1;
    state_t     state_next;
    logic       accept;
    logic       cond_now;
    logic       flag_load;
    logic       cond_pass_p1;
    logic [3:0] flags_p1;

    // The debug input has no effect in hardware.
    logic       unused_debug;
    assign unused_debug = debug;

    // Flags are packed {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c & !z;
            4'b1001: r = !c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign outValid  = (state_p1 == FULL);
    assign inReady   = !outValid | outReady;
    assign accept    = inValid & inReady;
    assign cond_now  = cond_eval(condField, flags_p1);
    assign flag_load = accept & flagWrite & cond_now;

    always_comb begin
        state_next = state_p1;
        case (state_p1)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (outReady && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Stage p1: output register and architectural flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_pass_p1 <= 1'b0;
        end else if (accept) begin
            cond_pass_p1 <= cond_now;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_p1 <= 4'b0000;
        end else if (flag_load) begin
            flags_p1 <= {aluN, aluZ, aluC, aluV};
        end
    end

    assign condPass = cond_pass_p1;
    assign nzcv     = flags_p1;
    assign carryOut = flags_p1[1];

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: vector table with hand-computed results, hand sequences for
// backpressure and reset, plus a scoreboard monitor checking every consumed result.
module tb_flag_cond_unit;

    logic       clk;
    logic       reset;
    logic       aluC, aluZ, aluN, aluV;
    logic       flagWrite;
    logic [3:0] condField;
    logic       inValid;
    logic       inReady;
    logic       outValid;
    logic       outReady;
    logic       condPass;
    logic       carryOut;
    logic [3:0] nzcv;
    logic       debug;

    int total = 0;
    int bad   = 0;

    flag_cond_unit dut (
        .clk(clk), .reset(reset),
        .aluC(aluC), .aluZ(aluZ), .aluN(aluN), .aluV(aluV),
        .flagWrite(flagWrite), .condField(condField),
        .inValid(inValid), .inReady(inReady),
        .outValid(outValid), .outReady(outReady),
        .condPass(condPass), .carryOut(carryOut),
        .nzcv(nzcv), .debug(debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference condition model: pairs of opposite conditions share a base test.
    function automatic bit m_eval(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cf, v, b;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !b : b;
    endfunction

    // Scoreboard monitor on the falling edge, predicting the following rising edge.
    bit        mon_en = 0;
    bit        exp_q[$];
    bit [3:0]  m_nzcv = 4'b0000;
    int        acc_count = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("sb_nzcv", nzcv, m_nzcv);
            chk("sb_carry", {3'b000, carryOut}, {3'b000, m_nzcv[1]});
            chk("sb_outValid", {3'b000, outValid}, {3'b000, exp_q.size() != 0});
            chk("sb_inReady", {3'b000, inReady}, {3'b000, (exp_q.size() == 0) || outReady});
            if (reset) begin
                exp_q.delete();
                m_nzcv = 4'b0000;
            end else begin
                if (outValid && outReady) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 4'd1, 4'd0);
                    end else begin
                        chk("sb_condPass", {3'b000, condPass}, {3'b000, exp_q.pop_front()});
                    end
                end
                if (inValid && inReady) begin
                    bit p;
                    p = m_eval(condField, m_nzcv);
                    exp_q.push_back(p);
                    acc_count++;
                    if (flagWrite && p) m_nzcv = {aluN, aluZ, aluC, aluV};
                end
            end
        end
    end

    typedef struct {
        logic [3:0] cond;
        logic       fw;
        logic [3:0] alu;      // {N,Z,C,V}
        logic       exp_pass;
        logic [3:0] exp_nzcv;
    } vec_t;

    vec_t vecs[18];

    task automatic drive(input logic [3:0] c, input logic fw, input logic [3:0] alu);
        condField = c;
        flagWrite = fw;
        {aluN, aluZ, aluC, aluV} = alu;
    endtask

    initial begin
        int acc_before;
        vecs[0]  = '{4'b1110, 1'b0, 4'b0000, 1'b1, 4'b0000};
        vecs[1]  = '{4'b1110, 1'b1, 4'b0110, 1'b1, 4'b0110};
        vecs[2]  = '{4'b0000, 1'b0, 4'b1111, 1'b1, 4'b0110};
        vecs[3]  = '{4'b1000, 1'b0, 4'b1111, 1'b0, 4'b0110};
        vecs[4]  = '{4'b1111, 1'b1, 4'b1111, 1'b0, 4'b0110};
        vecs[5]  = '{4'b0001, 1'b1, 4'b1001, 1'b0, 4'b0110};
        vecs[6]  = '{4'b0010, 1'b1, 4'b1001, 1'b1, 4'b1001};
        vecs[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b1001};
        vecs[8]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 4'b1001};
        vecs[9]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 4'b1001};
        vecs[10] = '{4'b1100, 1'b0, 4'b0000, 1'b1, 4'b1001};
        vecs[11] = '{4'b1101, 1'b0, 4'b0000, 1'b0, 4'b1001};
        vecs[12] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 4'b1001};
        vecs[13] = '{4'b0011, 1'b1, 4'b0000, 1'b1, 4'b0000};
        vecs[14] = '{4'b1001, 1'b0, 4'b1111, 1'b1, 4'b0000};
        vecs[15] = '{4'b0101, 1'b0, 4'b1111, 1'b1, 4'b0000};
        vecs[16] = '{4'b0111, 1'b0, 4'b1111, 1'b1, 4'b0000};
        vecs[17] = '{4'b1110, 1'b1, 4'b1111, 1'b1, 4'b1111};

        debug    = 1'b0;
        reset    = 1'b1;
        inValid  = 1'b1;
        outReady = 1'b0;
        drive(4'b1110, 1'b1, 4'b1111);
        repeat (2) cycle();
        chk("rst_outValid", {3'b000, outValid}, 4'd0);
        chk("rst_condPass", {3'b000, condPass}, 4'd0);
        chk("rst_nzcv", nzcv, 4'b0000);
        chk("rst_carry", {3'b000, carryOut}, 4'd0);
        chk("rst_inReady", {3'b000, inReady}, 4'd1);

        reset    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        mon_en   = 1'b1;

        // Back-to-back table with the consumer always ready.
        inValid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].cond, vecs[i].fw, vecs[i].alu);
            cycle();
            chk($sformatf("vec%0d_outValid", i), {3'b000, outValid}, 4'd1);
            chk($sformatf("vec%0d_condPass", i), {3'b000, condPass}, {3'b000, vecs[i].exp_pass});
            chk($sformatf("vec%0d_nzcv", i), nzcv, vecs[i].exp_nzcv);
            chk($sformatf("vec%0d_carry", i), {3'b000, carryOut}, {3'b000, vecs[i].exp_nzcv[1]});
        end

        // Drain, then backpressure with a second instruction waiting.
        inValid = 1'b0;
        cycle();
        chk("drain_outValid", {3'b000, outValid}, 4'd0);
        acc_before = acc_count;
        outReady = 1'b0;
        inValid  = 1'b1;
        drive(4'b0000, 1'b0, 4'b0000);
        cycle();
        chk("bp_first_valid", {3'b000, outValid}, 4'd1);
        chk("bp_first_pass", {3'b000, condPass}, 4'd1);
        drive(4'b0001, 1'b0, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_inReady", k), {3'b000, inReady}, 4'd0);
            cycle();
            chk($sformatf("bp%0d_valid", k), {3'b000, outValid}, 4'd1);
            chk($sformatf("bp%0d_pass_held", k), {3'b000, condPass}, 4'd1);
        end
        chk("bp_one_accept", acc_count - acc_before, 1);
        outReady = 1'b1;
        #1;
        chk("bp_release_inReady", {3'b000, inReady}, 4'd1);
        cycle();
        chk("bp_nobubble_valid", {3'b000, outValid}, 4'd1);
        chk("bp_nobubble_pass", {3'b000, condPass}, 4'd0);
        chk("bp_two_accepts", acc_count - acc_before, 2);
        chk("bp_nzcv", nzcv, 4'b1111);

        // Reset while a result is held and a flag-writing accept is offered.
        outReady = 1'b0;
        drive(4'b1110, 1'b1, 4'b0110);
        reset = 1'b1;
        cycle();
        chk("mid_rst_outValid", {3'b000, outValid}, 4'd0);
        chk("mid_rst_nzcv", nzcv, 4'b0000);
        chk("mid_rst_condPass", {3'b000, condPass}, 4'd0);
        chk("mid_rst_carry", {3'b000, carryOut}, 4'd0);
        reset    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        #1;
        chk("mid_rst_inReady", {3'b000, inReady}, 4'd1);
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
